// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared definitions for the audio waveform generator.
//                Holds the wave_sel encodings, the sample width, the square
//                amplitude constants and the raw-waveform helper function.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

   localparam int SAMPLE_W = 24;

   typedef enum logic [1:0] {
      WAVE_SILENCE = 2'd0,
      WAVE_SQUARE  = 2'd1,
      WAVE_SAW     = 2'd2,
      WAVE_TRI     = 2'd3
   } wave_e;

   // Square peaks are symmetric (+/- (2^23 - 1)) so the waveform has no DC bias.
   localparam logic [SAMPLE_W-1:0] SQUARE_POS = 24'h7FFFFF;
   localparam logic [SAMPLE_W-1:0] SQUARE_NEG = 24'h800001;
   // Offset that maps the unsigned phase range onto signed full scale.
   localparam logic [SAMPLE_W-1:0] MID_SCALE  = 24'h800000;

   // Raw full-scale sample for a waveform at phase p (top SAMPLE_W phase bits).
   function automatic logic [SAMPLE_W-1:0] raw_sample(
      input wave_e               sel,
      input logic [SAMPLE_W-1:0] p
   );
      logic [SAMPLE_W-2:0] t;
      raw_sample = '0;
      // Triangle folds the second half of the cycle back down.
      t = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
      case (sel)
         WAVE_SQUARE: raw_sample = p[SAMPLE_W-1] ? SQUARE_NEG : SQUARE_POS;
         WAVE_SAW:    raw_sample = p - MID_SCALE;
         WAVE_TRI:    raw_sample = {t, 1'b0} - MID_SCALE;
         default:     raw_sample = '0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/audio_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : audio_tick_gen
//  Description : Sample-rate divider. Counts 0..CLK_DIV-1 and wraps; tick is
//                high for the single cycle where the count is CLK_DIV-1.
//  Ports       : clk    - sample-domain clock
//                rst_n  - asynchronous active-low reset
//                tick   - one-cycle sample strobe
//                count  - current divider count
//  Revision    : 1.0  initial release
// ============================================================================
module audio_tick_gen #(
   parameter int CLK_DIV = 626,
   parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (r_count == c_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;
   assign tick  = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/audio_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : audio_wave_gen
//  Description : Phase-accumulator audio tone generator (square / saw /
//                triangle) with 3-bit volume attenuation and a two-stage
//                sample pipeline. Controls are sampled only on the sample tick.
//  Ports       : clk          - sample-domain clock (clk30)
//                rst_n        - asynchronous active-low reset
//                enable       - run; low gives silence and clears the phase
//                freq_word    - phase increment per sample
//                wave_sel     - 0 silence, 1 square, 2 saw, 3 triangle
//                volume       - 0 mute, 1..7 (7 = full scale)
//                audioL/R     - signed 24-bit samples
//                sample_valid - one-cycle pulse when audioL/R update
//  Options     : AUDIO_STEREO_INV_EN - when defined, audioR carries the
//                saturated negation of audioL; otherwise audioR = audioL.
//  Notes       : PHASE_W must be at least SAMPLE_W (24).
//  Revision    : 1.0  initial release
// ============================================================================
module audio_wave_gen
   import audio_pkg::*;
#(
   parameter int CLK_DIV = 626,
   parameter int PHASE_W = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PHASE_W-1:0]  freq_word,
   input  logic [1:0]          wave_sel,
   input  logic [2:0]          volume,
   output logic [SAMPLE_W-1:0] audioL,
   output logic [SAMPLE_W-1:0] audioR,
   output logic                sample_valid
);

   localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic                w_tick;
   logic [PHASE_W-1:0]  w_phase_next;
   logic [SAMPLE_W-1:0] w_p;
   logic [SAMPLE_W-1:0] w_raw;
   logic [SAMPLE_W-1:0] w_s;
   logic [SAMPLE_W-1:0] w_r;

   logic [PHASE_W-1:0]  r_phase;
   logic [SAMPLE_W-1:0] r_raw;
   logic [2:0]          r_vol;
   logic                r_en;
   logic                r_valid1;
   logic [SAMPLE_W-1:0] r_audio_l;
   logic [SAMPLE_W-1:0] r_audio_r;
   logic                r_valid2;

   audio_tick_gen #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (c_cnt_w)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick),
      .count ()
   );

   // ---------------- Stage 1: phase update and raw waveform ----------------
   // Modular wrap of the accumulator is intentional (no saturation).
   assign w_phase_next = enable ? (r_phase + freq_word) : '0;
   assign w_p          = w_phase_next[PHASE_W-1 -: SAMPLE_W];
   assign w_raw        = raw_sample(wave_e'(wave_sel), w_p);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= '0;
         r_raw    <= '0;
         r_vol    <= '0;
         r_en     <= 1'b0;
         r_valid1 <= 1'b0;
      end else begin
         r_valid1 <= w_tick;
         // Controls are captured only here so mid-period changes are inert.
         if (w_tick) begin
            r_phase <= w_phase_next;
            r_raw   <= w_raw;
            r_vol   <= volume;
            r_en    <= enable;
         end
      end
   end

   // ---------------- Stage 2: volume scaling ----------------
   // Each volume step below 7 halves the amplitude (arithmetic shift keeps sign).
   always_comb begin
      w_s = '0;
      if (r_en && (r_vol != 3'd0)) begin
         w_s = $signed(r_raw) >>> (3'd7 - r_vol);
      end
   end

`ifdef AUDIO_STEREO_INV_EN
   // -(-2^23) is not representable; clamp it to positive full scale.
   assign w_r = (w_s == MID_SCALE) ? SQUARE_POS : -w_s;
`else
   assign w_r = w_s;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_audio_l <= '0;
         r_audio_r <= '0;
         r_valid2  <= 1'b0;
      end else begin
         r_valid2 <= r_valid1;
         if (r_valid1) begin
            r_audio_l <= w_s;
            r_audio_r <= w_r;
         end
      end
   end

   assign audioL       = r_audio_l;
   assign audioR       = r_audio_r;
   assign sample_valid = r_valid2;

endmodule
`default_nettype wire

// File: tb/tb_audio_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_wave_gen
//  Description : Self-checking bench for audio_wave_gen. A cycle-indexed
//                model predicts every sample from the phase/waveform rules
//                and checks all outputs each cycle; directed scenarios pin
//                the model with hand-computed sample values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_wave_gen;

   localparam int CLK_DIV = 626;
   localparam int PHASE_W = 24;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic [PHASE_W-1:0] freq_word = '0;
   logic [1:0]         wave_sel = 2'd0;
   logic [2:0]         volume = 3'd0;
   logic [23:0]        audioL;
   logic [23:0]        audioR;
   logic               sample_valid;

   int n_checks = 0;
   int n_fail   = 0;

   audio_wave_gen #(
      .CLK_DIV (CLK_DIV),
      .PHASE_W (PHASE_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .freq_word    (freq_word),
      .wave_sel     (wave_sel),
      .volume       (volume),
      .audioL       (audioL),
      .audioR       (audioR),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Signed sample value from the waveform definitions using plain integers.
   function automatic int model_val(int p, int sel, int vol, bit en);
      int v;
      int d;
      v = 0;
      if (!en || vol == 0) return 0;
      case (sel)
         1: v = (p >= (1 << 23)) ? -((1 << 23) - 1) : ((1 << 23) - 1);
         2: v = p - (1 << 23);
         3: v = 2 * ((p < (1 << 23)) ? p : ((1 << 24) - 1 - p)) - (1 << 23);
         default: v = 0;
      endcase
      d = 1 << (7 - vol);
      // Floor division = arithmetic right shift for negatives.
      if (v >= 0) return v / d;
      return -(((-v) + d - 1) / d);
   endfunction

   typedef struct {
      int          due;
      logic [23:0] l;
      logic [23:0] r;
   } exp_t;

   exp_t        q[$];
   int          cyc;
   longint      mphase;
   logic [23:0] hold_l;
   logic [23:0] hold_r;
   logic        exp_v;
   exp_t        e;
   int          mv;
   int          nv;
   int          p24;

   // Cycle index = posedges since reset release. The tick occurs in the cycle
   // whose index is CLK_DIV-1 mod CLK_DIV; its sample is visible two cycles on.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         cyc    = 0;
         mphase = 0;
         hold_l = '0;
         hold_r = '0;
         chk("rst_valid", {23'd0, sample_valid}, 24'd0);
         chk("rst_audioL", audioL, 24'd0);
         chk("rst_audioR", audioR, 24'd0);
      end else begin
         exp_v = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_v  = 1'b1;
            hold_l = q[0].l;
            hold_r = q[0].r;
            void'(q.pop_front());
         end
         chk("sample_valid", {23'd0, sample_valid}, {23'd0, exp_v});
         chk("audioL", audioL, hold_l);
         chk("audioR", audioR, hold_r);
         if (cyc % CLK_DIV == CLK_DIV - 1) begin
            mphase = enable ? ((mphase + longint'(freq_word)) % (longint'(1) << PHASE_W)) : 0;
            p24    = int'(mphase >> (PHASE_W - 24));
            mv     = model_val(p24, int'(wave_sel), int'(volume), enable);
            e.due  = cyc + 2;
            e.l    = mv[23:0];
`ifdef AUDIO_STEREO_INV_EN
            nv     = (mv == -(1 << 23)) ? ((1 << 23) - 1) : -mv;
`else
            nv     = mv;
`endif
            e.r    = nv[23:0];
            q.push_back(e);
         end
         cyc++;
      end
   end

   task automatic do_reset(input logic [1:0] sel, input logic [23:0] fw,
                           input logic [2:0] vol, input logic en);
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      wave_sel  = sel;
      freq_word = fw;
      volume    = vol;
      enable    = en;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Waits for the next sample_valid pulse; k = negedges consumed (0-based).
   task automatic wait_valid(output logic [23:0] l, output logic [23:0] r, output int k);
      l = 'x;
      r = 'x;
      for (k = 0; k < 2 * CLK_DIV + 4; k++) begin
         @(negedge clk);
         if (sample_valid) begin
            l = audioL;
            r = audioR;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: no sample_valid within %0d cycles", 2 * CLK_DIV + 4);
   endtask

   logic [23:0] sl, sr;
   logic [23:0] saw_seq[16];
   int          k;
   int          pulses;
   logic [23:0] sq_exp[4]  = '{24'h7FFFFF, 24'h800001, 24'h800001, 24'h7FFFFF};
   logic [23:0] tri_exp[5] = '{24'hF80000, 24'h000000, 24'h080000, 24'h0FFFFF, 24'h07FFFF};

   initial begin
      // Reset state and first-sample latency with the default silence selection.
      do_reset(2'd0, 24'h0, 3'd0, 1'b0);
      wait_valid(sl, sr, k);
      chk("first_valid_cycle", 24'(k), 24'd627);
      chk("first_audioL", sl, 24'h000000);

      // Square, full volume, quarter-cycle step.
      do_reset(2'd1, 24'h400000, 3'd7, 1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_valid(sl, sr, k);
         chk("square_seq", sl, sq_exp[i]);
      end

      // Saw, full volume, 1/16 step: ramps up and wraps 700000 -> 800000.
      do_reset(2'd2, 24'h100000, 3'd7, 1'b1);
      for (int i = 0; i < 16; i++) begin
         wait_valid(sl, sr, k);
         saw_seq[i] = sl;
         chk("saw_ramp", sl, 24'h900000 + 24'(i) * 24'h100000);
      end
      chk("saw_before_wrap", saw_seq[14], 24'h700000);
      chk("saw_after_wrap", saw_seq[15], 24'h800000);

      // Triangle at volume 4 (>>> 3), sign preserved.
      do_reset(2'd3, 24'h200000, 3'd4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         wait_valid(sl, sr, k);
         chk("tri_vol4", sl, tri_exp[i]);
      end

      // Mid-period changes take effect only at the next tick.
      do_reset(2'd2, 24'h100000, 3'd7, 1'b1);
      wait_valid(sl, sr, k);
      chk("mid_first", sl, 24'h900000);
      repeat (100) @(posedge clk);
      #2;
      wave_sel  = 2'd1;
      freq_word = 24'h400000;
      repeat (50) @(posedge clk);
      #2;
      volume = 3'd0;
      repeat (10) @(posedge clk);
      #2;
      volume = 3'd7;
      @(negedge clk);
      chk("mid_hold", audioL, 24'h900000);
      wait_valid(sl, sr, k);
      chk("mid_new_settings", sl, 24'h7FFFFF);

      // Enable low: silence and phase cleared; restart from phase 0.
      @(posedge clk);
      #2;
      wave_sel  = 2'd2;
      freq_word = 24'h100000;
      enable    = 1'b0;
      wait_valid(sl, sr, k);
      chk("disabled", sl, 24'h000000);
      @(posedge clk);
      #2;
      enable = 1'b1;
      wait_valid(sl, sr, k);
      chk("reenabled", sl, 24'h900000);
      @(posedge clk);
      #2;
      volume = 3'd0;
      wait_valid(sl, sr, k);
      chk("mute", sl, 24'h000000);

      // DC output at freq 0; saw at phase 0 gives the most negative sample.
      do_reset(2'd2, 24'h000000, 3'd7, 1'b1);
      for (int i = 0; i < 2; i++) begin
         wait_valid(sl, sr, k);
         chk("dc_audioL", sl, 24'h800000);
`ifdef AUDIO_STEREO_INV_EN
         chk("dc_audioR", sr, 24'h7FFFFF);
`else
         chk("dc_audioR", sr, 24'h800000);
`endif
      end

      // Reset mid-pipeline discards the in-flight sample.
      do_reset(2'd1, 24'h400000, 3'd7, 1'b1);
      repeat (CLK_DIV) @(posedge clk);
      #2;
      rst_n  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sample_valid) pulses++;
      end
      chk("no_valid_after_reset", 24'(pulses), 24'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      wait_valid(sl, sr, k);
      chk("restart_cycle", 24'(k), 24'd627);
      chk("restart_audioL", sl, 24'h7FFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
